// File: rtl/multicycle_control.sv
// Moore sequencing controller for the multicycle RV32I core: walks each instruction
// through fetch/decode/execute/memory/writeback and drives datapath enables and selects.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;
    localparam logic [3:0] AluXor = 4'b0100;
    localparam logic [3:0] AluSlt = 4'b0101;
    localparam logic [3:0] AluSll = 4'b0110;
    localparam logic [3:0] AluSrl = 4'b0111;
    localparam logic [3:0] AluSra = 4'b1000;

    state_e state_q, state_d;

    logic       is_load, is_store, is_rtype, is_itype, is_beq, is_jal, is_legal;
    logic [3:0] funct_alu;
    logic [1:0] imm_src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        is_load  = (op == OpLoad);
        is_store = (op == OpStore);
        is_rtype = (op == OpRType);
        is_itype = (op == OpIType);
        is_beq   = (op == OpBeq);
        is_jal   = (op == OpJal);
        is_legal = is_load | is_store | is_rtype | is_itype | is_beq | is_jal;
    end

    // Subtract only for R-type; addi must ignore instr[30] since it is immediate data.
    always_comb begin
        funct_alu = AluAdd;
        unique case (funct3)
            3'b000:  funct_alu = (is_rtype && funct7b5) ? AluSub : AluAdd;
            3'b001:  funct_alu = AluSll;
            3'b010:  funct_alu = AluSlt;
            3'b011:  funct_alu = AluAdd;
            3'b100:  funct_alu = AluXor;
            3'b101:  funct_alu = funct7b5 ? AluSra : AluSrl;
            3'b110:  funct_alu = AluOr;
            3'b111:  funct_alu = AluAnd;
            default: funct_alu = AluAdd;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        if (is_store) begin
            imm_src = 2'b01;
        end else if (is_beq) begin
            imm_src = 2'b10;
        end else if (is_jal) begin
            imm_src = 2'b11;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                if (is_load || is_store) begin
                    state_d = StMemAdr;
                end else if (is_rtype) begin
                    state_d = StExecuteR;
                end else if (is_itype) begin
                    state_d = StExecuteI;
                end else if (is_beq) begin
                    state_d = StBeq;
                end else if (is_jal) begin
                    state_d = StJal;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemAdr:   state_d = is_load ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = AluAdd;
        ImmSrc     = imm_src;
        RegWrite   = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            // Branch target is computed here from OldPC so BEQ can compare in its own cycle.
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = ~is_legal;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
            end
            StMemWb: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StExecuteR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = funct_alu;
            end
            StExecuteI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = funct_alu;
            end
            StAluWb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StBeq: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = AluSub;
                PCWrite    = zero;
                instr_done = 1'b1;
            end
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase

        // Reset silences every output immediately, independent of the clock.
        if (reset) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUControl = AluAdd;
            ImmSrc     = 2'b00;
            RegWrite   = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, reset corner case and
// randomized instructions checked against an instruction-level reference model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl, state;

    int n_cmp  = 0;
    int n_fail = 0;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .illegal    (illegal),
        .instr_done (instr_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
    //  RegWrite, illegal, instr_done}
    logic [18:0] outs;
    assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, ImmSrc, RegWrite, illegal, instr_done};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // ALU operation by instruction meaning: index by funct3, then the instr[30] variants.
    function automatic logic [3:0] alu_of(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
        logic [3:0] base [8];
        base = '{4'd0, 4'd6, 4'd5, 4'd0, 4'd4, 4'd7, 4'd3, 4'd2};
        if (f3 == 3'd0 && o == 7'b0110011 && f7) return 4'd1;
        if (f3 == 3'd5 && f7) return 4'd8;
        return base[f3];
    endfunction

    // Expected state path of a whole instruction, first state in the top nibble.
    task automatic model_path(input logic [6:0] o, output int n, output logic [19:0] seq);
        case (o)
            7'b0000011: begin n = 5; seq = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}; end
            7'b0100011: begin n = 4; seq = {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}; end
            7'b0110011: begin n = 4; seq = {4'd0, 4'd1, 4'd6, 4'd8, 4'd0}; end
            7'b0010011: begin n = 4; seq = {4'd0, 4'd1, 4'd7, 4'd8, 4'd0}; end
            7'b1100011: begin n = 3; seq = {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}; end
            7'b1101111: begin n = 4; seq = {4'd0, 4'd1, 4'd10, 4'd8, 4'd0}; end
            default:    begin n = 2; seq = {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}; end
        endcase
    endtask

    function automatic logic [18:0] model_out(input int st, input logic [6:0] o,
                                              input logic [2:0] f3, input logic f7,
                                              input logic z);
        logic       pcw, adr, mw, irw, rw, ill, done;
        logic [1:0] rs, sa, sb, imm;
        logic [3:0] alu;
        {pcw, adr, mw, irw, rw, ill, done} = '0;
        rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 4'd0;
        imm = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 :
              (o == 7'b1101111) ? 2'd3 : 2'd0;
        case (st)
            0:  begin irw = 1; pcw = 1; sb = 2; rs = 2; end
            1:  begin sa = 1; sb = 1; ill = !is_legal(o); end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; done = 1; end
            5:  begin adr = 1; mw = 1; done = 1; end
            6:  begin sa = 2; alu = alu_of(o, f3, f7); end
            7:  begin sa = 2; sb = 1; alu = alu_of(o, f3, f7); end
            8:  begin rw = 1; done = 1; end
            9:  begin sa = 2; alu = 4'd1; pcw = z; done = 1; end
            10: begin sa = 1; sb = 2; pcw = 1; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill, done};
    endfunction

    // Starts and ends just after a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int n, input logic [19:0] seq,
                             input logic use_tab, input logic [3:0] ealu,
                             input logic [1:0] eimm, input string tag);
        int     dones = 0;
        logic [3:0] st;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int i = 0; i < n; i++) begin
            #1;
            st = seq[4*(4-i) +: 4];
            check({tag, " state"}, 32'(state), 32'(st));
            check({tag, " outputs"}, 32'(outs), 32'(model_out(int'(st), o, f3, f7, z)));
            if (use_tab) begin
                check({tag, " ImmSrc"}, 32'(ImmSrc), 32'(eimm));
                if (st == 4'd6 || st == 4'd7 || st == 4'd9)
                    check({tag, " ALUControl"}, 32'(ALUControl), 32'(ealu));
            end
            if (instr_done) dones++;
            @(negedge clk);
        end
        check({tag, " done count"}, dones, is_legal(o) ? 1 : 0);
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        int          n;
        logic [19:0] seq;
        logic [3:0]  alu;
        logic [1:0]  imm;
        string       name;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int          n;
        logic [19:0] seq;
        logic [6:0]  o;
        vecs[0]  = '{7'b0000011, 3'd2, 1'b0, 1'b0, 5, 20'h01234, 4'd0, 2'd0, "lw"};
        vecs[1]  = '{7'b0100011, 3'd2, 1'b0, 1'b0, 4, 20'h01250, 4'd0, 2'd1, "sw"};
        vecs[2]  = '{7'b0110011, 3'd0, 1'b1, 1'b0, 4, 20'h01680, 4'd1, 2'd0, "sub"};
        vecs[3]  = '{7'b0110011, 3'd0, 1'b0, 1'b0, 4, 20'h01680, 4'd0, 2'd0, "add"};
        vecs[4]  = '{7'b0010011, 3'd0, 1'b1, 1'b0, 4, 20'h01780, 4'd0, 2'd0, "addi_f7"};
        vecs[5]  = '{7'b0010011, 3'd5, 1'b1, 1'b0, 4, 20'h01780, 4'd8, 2'd0, "srai"};
        vecs[6]  = '{7'b0110011, 3'd5, 1'b0, 1'b0, 4, 20'h01680, 4'd7, 2'd0, "srl"};
        vecs[7]  = '{7'b0110011, 3'd1, 1'b0, 1'b0, 4, 20'h01680, 4'd6, 2'd0, "sll"};
        vecs[8]  = '{7'b0110011, 3'd2, 1'b0, 1'b0, 4, 20'h01680, 4'd5, 2'd0, "slt"};
        vecs[9]  = '{7'b0010011, 3'd4, 1'b0, 1'b0, 4, 20'h01780, 4'd4, 2'd0, "xori"};
        vecs[10] = '{7'b0110011, 3'd6, 1'b0, 1'b0, 4, 20'h01680, 4'd3, 2'd0, "or"};
        vecs[11] = '{7'b0010011, 3'd7, 1'b0, 1'b0, 4, 20'h01780, 4'd2, 2'd0, "andi"};
        vecs[12] = '{7'b1100011, 3'd0, 1'b0, 1'b1, 3, 20'h01900, 4'd1, 2'd2, "beq_taken"};
        vecs[13] = '{7'b1100011, 3'd0, 1'b0, 1'b0, 3, 20'h01900, 4'd1, 2'd2, "beq_not"};
        vecs[14] = '{7'b1101111, 3'd0, 1'b0, 1'b0, 4, 20'h01a80, 4'd0, 2'd3, "jal"};
        vecs[15] = '{7'b1111111, 3'd0, 1'b0, 1'b0, 2, 20'h01000, 4'd0, 2'd0, "illegal"};

        reset = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1; zero = 1'b1;
        #12;
        check("reset state", 32'(state), 32'd0);
        check("reset outputs", 32'(outs), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].n, vecs[i].seq,
                      1'b1, vecs[i].alu, vecs[i].imm, vecs[i].name);

        // Reset in the middle of an lw, while in MEMREAD.
        op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("lw reach memread", 32'(state), 32'd3);
        #1 reset = 1'b1;
        #1;
        check("async reset state", 32'(state), 32'd0);
        check("async reset PCWrite", 32'(PCWrite), 32'd0);
        check("async reset RegWrite", 32'(RegWrite), 32'd0);
        check("async reset outputs", 32'(outs), 32'd0);
        @(posedge clk);
        #1 check("held reset state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 5, 20'h01234, 1'b1, 4'd0, 2'd0, "lw_after_rst");

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 6))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1100011;
                5: o = 7'b1101111;
                default: o = 7'($urandom);
            endcase
            model_path(o, n, seq);
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), n, seq, 1'b0, 4'd0, 2'd0,
                      "random");
        end
        #1 check("final state", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle RV32I core. It replaces the single-cycle control decoder once instruction and data memory are merged into one memory and the ALU also performs PC increment. A Moore state machine walks each instruction through fetch, decode, execute, memory and writeback. Every cycle it drives the enables and mux selects for the IR, PC, register file, shared memory and ALU.

## Interface
Parameters:
- none (RV32I subset fixed: lw, sw, R-type ALU, I-type ALU, beq, jal)

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; state forced to FETCH
- op  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12] from IR
- funct7b5  in  1  instr[30] from IR
- zero  in  1  ALU Zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 = ALUOut reg, 01 = Data reg, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A reg
- ALUSrcB  out  2  00 = WriteData reg, 01 = ImmExt, 10 = constant 4
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- illegal  out  1  one-cycle pulse in DECODE for an unsupported op
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- state  out  4  current state encoding, for debug and verification

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11–15 are unreachable and go to FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE:
    - op 0000011 or 0100011 → MEMADR
    - op 0110011 → EXECUTER
    - op 0010011 → EXECUTEI
    - op 1100011 → BEQ
    - op 1101111 → JAL
    - any other op → FETCH with illegal=1
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
- Outputs per state. Any signal not listed is 0; ALUControl defaults to add.
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, add.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (precomputes the branch target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, instr_done=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, funct decode.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct decode.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero, instr_done=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
- Funct decode by funct3:
  - 000 → sub only if op=0110011 and funct7b5=1, else add
  - 001 → sll; 010 → slt; 100 → xor; 110 → or; 111 → and
  - 101 → sra if funct7b5=1, else srl
  - 011 → add
- ImmSrc is combinational from op in every state:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - all other ops → 00
- Outputs are decoded from state only, plus op/funct/zero; there are no registered outputs.

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3. Illegal op takes 2 cycles, and PC has already advanced by 4.
- Reset asserted, at any time including mid-instruction:
  - state=FETCH immediately, without waiting for a clock.
  - All enables (PCWrite, IRWrite, MemWrite, RegWrite), illegal and instr_done are forced to 0 while reset is high.
  - All selects are 00/0, ALUControl=0000, ImmSrc=00.
- First rising edge after reset deasserts: FETCH outputs are active in that cycle, and state moves to DECODE on that edge.
- op, funct3 and funct7b5 are sampled in DECODE and must remain stable from DECODE to instruction end; the IR is written only in FETCH.
- zero is used combinationally in BEQ only. A taken branch loads PC from ALUOut at the BEQ edge.
- Exactly one instr_done pulse per supported instruction; none for illegal ops.

## Test plan
- Reset mid-MEMREAD of an lw → state=0 with no clock edge, PCWrite=0, RegWrite=0; after release, state sequence is 0,1.
- lw (op 0000011) → states 0,1,2,3,4. MEMREAD has AdrSrc=1. MEMWB has ResultSrc=01, RegWrite=1, instr_done=1. ImmSrc=00 throughout.
- sw (op 0100011) → states 0,1,2,5. MemWrite=1 only in state 5. ImmSrc=01. RegWrite never 1.
- R-type sub (funct3 000, funct7b5=1) → EXECUTER has ALUControl=0001. Same encoding in EXECUTEI (op 0010011) → 0000. srai (funct3 101, funct7b5=1) → 1000.
- beq with zero=1 → BEQ has PCWrite=1, ALUControl=0001. With zero=0 → PCWrite=0. Both return to state 0 after 3 cycles.
- jal → states 0,1,10,8 with PCWrite=1 in JAL and ImmSrc=11. Op 1111111 → illegal=1 in DECODE, then state 0, no instr_done.
